heater_ctrl: RTL and testbench
==============================

Name: heater_ctrl

Overview:
- Sequencer and error manager for the array of N heater instances in the top level, all on the 200 MHz fabric clock.
- Ramps the number of active heaters up and down one instance at a time, so supply current steps gradually rather than all at once.
- Latches and counts per-heater error reports and generates the err_clear pulses, taking over the err_clear drive the VIO provides today.
- The VIO drives the command inputs and reads the status outputs.

Parameters:
- N, 32, number of heater instances controlled.
- STEP_CYCLES, 1024, clock cycles between successive enable steps while ramping (must be >= 2).
- CNT_W, 16, width of the saturating error event counter.

Ports:
- clk  in  1  fabric clock (clk_out200 domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; request ramp toward target.
- stop  in  1  level; request ramp down to zero active heaters.
- target  in  $clog2(N+1)  requested active heater count; values > N are clamped to N.
- abort_on_err  in  1  1 = any new error forces a ramp-down.
- sw_clear  in  1  single-cycle pulse; clears sticky bits and counter, pulses all err_clear lines.
- error  in  N  per-heater error flags.
- enable  out  N  thermometer-coded; the top level drives heater i reset as ~enable[i].
- err_clear  out  N  per-heater clear pulses.
- err_sticky  out  N  latched errors.
- err_count  out  CNT_W  total error events, saturating.
- active_cnt  out  $clog2(N+1)  number of heaters currently enabled.
- state  out  2  0=IDLE, 1=RAMP_UP, 2=HOLD, 3=RAMP_DOWN.
- ramp_done  out  1  high while in HOLD.

Behaviour:
Reset:
- Async reset sets every output and internal register to 0; state = IDLE.
- Reset asserted mid-ramp drops all enables in the same cycle.

Enable and step timing:
- enable[i] = (i < active_cnt), registered.
- step_cnt is cleared on entry to any ramp state and counts every cycle in RAMP_UP/RAMP_DOWN.
- When step_cnt == STEP_CYCLES-1, active_cnt changes by ±1 and step_cnt wraps to 0.

FSM:
- IDLE: stop has priority over start. On start, goes to RAMP_UP with tgt_q = min(target, N) latched.
- RAMP_UP:
  - stop or an abort event -> RAMP_DOWN.
  - active_cnt == tgt_q -> HOLD.
  - Otherwise step up.
- HOLD:
  - stop or abort -> RAMP_DOWN with tgt_q = 0.
  - A new target different from active_cnt re-latches tgt_q and goes to RAMP_UP or RAMP_DOWN as appropriate.
- RAMP_DOWN:
  - active_cnt == tgt_q -> HOLD, or -> IDLE if tgt_q == 0.
  - Otherwise step down.
  - start is ignored until IDLE or HOLD is reached.
- A target of 0 with start: IDLE -> RAMP_UP -> HOLD in 2 cycles with no enables.

Error handling (all states):
- error is synchronised through 2 flops.
- A new event on bit i is a 0->1 edge of the synchronised bit while enable[i] = 1.
- Each new event:
  - sets err_sticky[i];
  - gives err_clear[i] = 1 for exactly one cycle, the cycle after detection;
  - adds to err_count, with the increment equal to the popcount of the new events that cycle, saturating at 2^CNT_W-1.
- Errors on disabled heaters are ignored.
- An abort event = any new event while abort_on_err = 1; it sets tgt_q = 0.
- sw_clear:
  - zeroes err_sticky and err_count;
  - drives all err_clear lines high for one cycle;
  - if it coincides with new events, sw_clear wins for sticky/count, and err_clear stays a single pulse.

Decomposition:
- Package heater_pkg:
  - typedef state_t (IDLE, RAMP_UP, HOLD, RAMP_DOWN);
  - constant N_HEATERS = 32;
  - function popcount.
- One sub-module, heater_err_mon: the synchroniser, edge detection, sticky bits, counter and clear pulse. The FSM and step counter stay in heater_ctrl.

Test Plan:
- STEP_CYCLES=4, target=3, start at cycle 0 -> state=RAMP_UP at cycle 1; active_cnt 1/2/3 at cycles 5/9/13; HOLD with ramp_done=1 at cycle 14; enable=32'h7.
- In HOLD with 3 active, target=1 -> RAMP_DOWN; active_cnt 2 then 1 at 4-cycle spacing; HOLD; enable=32'h1.
- error[0] and error[2] rise together with 3 enabled -> err_sticky=32'h5, err_count=2, err_clear=32'h5 for one cycle. error[10] (disabled) -> no change.
- abort_on_err=1, error[1] rises mid-RAMP_UP -> RAMP_DOWN to 0 active, then IDLE; err_count=1.
- err_count preloaded near saturation via CNT_W=2 (four events) -> count holds at 3. sw_clear -> count=0, sticky=0, err_clear=all ones for one cycle.
- reset pulse while active_cnt=2 in RAMP_UP -> enable=0 and state=IDLE immediately (asynchronously); start and stop asserted together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared types and helpers for the heater sequencer slice.
package heater_pkg;

  // Sequencer states; the encoding is visible on the state status output.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int N_HEATERS = 32;

  // Widest vector popcount accepts; narrower vectors are zero-extended.
  localparam int POP_W = 256;

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/heater_if.sv
// Command/status bundle between the VIO and the heater sequencer.
//
// Signalling: there is no valid/ready handshake on this bundle. start, stop,
// target, abort_on_err and error are levels sampled on every rising clk edge;
// sw_clear is a single-cycle pulse acted on in the cycle it is high. Every
// status signal is a registered value (ramp_done decodes the state register).
interface heater_if #(
  parameter int N     = heater_pkg::N_HEATERS,
  parameter int CNT_W = 16
);
  localparam int TW = $clog2(N + 1);

  logic          start;
  logic          stop;
  logic [TW-1:0] target;
  logic          abort_on_err;
  logic          sw_clear;
  logic [N-1:0]  error;

  logic [N-1:0]     enable;
  logic [N-1:0]     err_clear;
  logic [N-1:0]     err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [TW-1:0]    active_cnt;
  logic [1:0]       state;
  logic             ramp_done;

  // VIO side: drives commands, reads status.
  modport master (
    output start, stop, target, abort_on_err, sw_clear, error,
    input  enable, err_clear, err_sticky, err_count, active_cnt, state, ramp_done
  );

  // Controller side.
  modport slave (
    input  start, stop, target, abort_on_err, sw_clear, error,
    output enable, err_clear, err_sticky, err_count, active_cnt, state, ramp_done
  );
endinterface

// File: rtl/heater_err_mon.sv
// Per-heater error monitor: synchroniser, rising-edge detect gated by enable,
// sticky bits, saturating event counter and one-cycle clear pulses.
module heater_err_mon
  import heater_pkg::*;
#(
  parameter int N     = N_HEATERS,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     error,
  input  logic [N-1:0]     enable,
  input  logic             sw_clear,
  output logic [N-1:0]     new_evt,
  output logic [N-1:0]     err_clear,
  output logic [N-1:0]     err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam int SUM_W = CNT_W + 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [N-1:0]     prev_q;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count_d;

  // Errors on disabled heaters never count as events.
  assign new_evt = sync2_q & ~prev_q & enable;

  // Saturating add of this cycle's event count.
  always_comb begin
    sum     = SUM_W'(err_count) + SUM_W'(popcount(POP_W'(new_evt)));
    count_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  // Two-flop synchroniser plus one extra stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= error;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Sticky/count/clear update; a software clear overrides same-cycle events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= '0;
      err_count  <= '0;
      err_clear  <= '0;
    end else if (sw_clear) begin
      err_sticky <= '0;
      err_count  <= '0;
      err_clear  <= '1;
    end else begin
      err_sticky <= err_sticky | new_evt;
      err_count  <= count_d;
      err_clear  <= new_evt;
    end
  end

endmodule

// File: rtl/heater_ctrl.sv
// Heater sequencer: ramps the thermometer-coded enable one heater per
// STEP_CYCLES, holds at the target and ramps down on stop or error abort.
module heater_ctrl
  import heater_pkg::*;
#(
  parameter int N           = N_HEATERS,
  parameter int STEP_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic  clk,
  input  logic  reset,
  heater_if.slave bus
);

  localparam int TW = $clog2(N + 1);
  localparam int SW = $clog2(STEP_CYCLES);

  state_t        state_q, state_d;
  logic [TW-1:0] active_q, active_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic [TW-1:0] tgt_in;
  logic [TW-1:0] tgt_eff;
  logic [SW-1:0] step_q, step_d;
  logic [N-1:0]  enable_q, enable_d;
  logic [N-1:0]  new_evt;
  logic          abort;
  logic          step_hit;

  heater_err_mon #(.N(N), .CNT_W(CNT_W)) u_err_mon (
    .clk        (clk),
    .reset      (reset),
    .error      (bus.error),
    .enable     (enable_q),
    .sw_clear   (bus.sw_clear),
    .new_evt    (new_evt),
    .err_clear  (bus.err_clear),
    .err_sticky (bus.err_sticky),
    .err_count  (bus.err_count)
  );

  assign tgt_in   = (bus.target > TW'(N)) ? TW'(N) : bus.target;
  assign abort    = bus.abort_on_err && (|new_evt);
  assign step_hit = (step_q == SW'(STEP_CYCLES - 1));

  // Next-state, target latch and step timing.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    tgt_eff  = tgt_q;
    if (abort) tgt_d = '0;
    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          state_d = RAMP_UP;
          tgt_d   = tgt_in;
          step_d  = '0;
        end
      end
      RAMP_UP: begin
        if (bus.stop || abort) begin
          state_d = RAMP_DOWN;
          tgt_d   = '0;
          step_d  = '0;
        end else if (active_q == tgt_q) begin
          state_d = HOLD;
        end else if (step_hit) begin
          active_d = active_q + 1'b1;
          step_d   = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.stop || abort) begin
          state_d = RAMP_DOWN;
          tgt_d   = '0;
          step_d  = '0;
        end else if (tgt_in != active_q) begin
          tgt_d   = tgt_in;
          step_d  = '0;
          state_d = (tgt_in > active_q) ? RAMP_UP : RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        // stop or abort while already ramping down retargets to zero.
        tgt_eff = (bus.stop || abort) ? '0 : tgt_q;
        tgt_d   = tgt_eff;
        if (active_q == tgt_eff) begin
          state_d = (tgt_eff == '0) ? IDLE : HOLD;
        end else if (step_hit) begin
          active_d = active_q - 1'b1;
          step_d   = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Thermometer code of the next active count, so enable tracks active_cnt.
  always_comb begin
    enable_d = '0;
    for (int i = 0; i < N; i++) begin
      enable_d[i] = (i < int'(active_d));
    end
  end

  // State register; reset drops every enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      enable_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      enable_q <= enable_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.active_cnt = active_q;
  assign bus.state      = state_q;
  assign bus.ramp_done  = (state_q == HOLD);

endmodule

// File: tb/tb_heater_ctrl.sv
// Bench for heater_ctrl: directed checks with literal expectations followed
// by randomized commands/errors, all compared against a behavioural model.
module tb_heater_ctrl;

  localparam int N     = 32;
  localparam int STEP  = 4;
  localparam int CNT_W = 2;
  localparam int TW    = $clog2(N + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  heater_if #(.N(N), .CNT_W(CNT_W)) bus ();

  heater_ctrl #(.N(N), .STEP_CYCLES(STEP), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // exp_q holds the last three sampled error vectors, oldest first.
  logic [N-1:0] exp_q[$];
  int           m_state;   // 0 idle, 1 up, 2 hold, 3 down
  int           m_active;
  int           m_tgt;
  longint       m_next;    // edge number at which the next step lands
  longint       cyc;
  logic [N-1:0] m_sticky;
  logic [N-1:0] m_clear;
  int           m_count;

  function automatic logic [N-1:0] thermo(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < k && i < N; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int pop(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] ev;
    bit ab;
    int clamp;
    int teff;
    if (rst) begin
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      m_state = 0; m_active = 0; m_tgt = 0; m_next = 0; cyc = 0;
      m_sticky = '0; m_clear = '0; m_count = 0;
    end else begin
      cyc++;
      ev = exp_q[1] & ~exp_q[0] & thermo(m_active);
      void'(exp_q.pop_front());
      exp_q.push_back(bus.error);
      ab    = bus.abort_on_err && (ev != '0);
      clamp = (int'(bus.target) > N) ? N : int'(bus.target);
      if (bus.sw_clear) begin
        m_sticky = '0; m_count = 0; m_clear = '1;
      end else begin
        m_sticky = m_sticky | ev;
        m_count  = (m_count + pop(ev) > CMAX) ? CMAX : m_count + pop(ev);
        m_clear  = ev;
      end
      if (ab) m_tgt = 0;
      case (m_state)
        0: if (!bus.stop && bus.start) begin
             m_state = 1; m_tgt = clamp; m_next = cyc + STEP;
           end
        1: if (bus.stop || ab) begin
             m_state = 3; m_tgt = 0; m_next = cyc + STEP;
           end else if (m_active == m_tgt) begin
             m_state = 2;
           end else if (cyc == m_next) begin
             m_active++; m_next = cyc + STEP;
           end
        2: if (bus.stop || ab) begin
             m_state = 3; m_tgt = 0; m_next = cyc + STEP;
           end else if (clamp != m_active) begin
             m_state = (clamp > m_active) ? 1 : 3;
             m_tgt = clamp; m_next = cyc + STEP;
           end
        default: begin
          teff  = (bus.stop || ab) ? 0 : m_tgt;
          m_tgt = teff;
          if (m_active == teff) m_state = (teff == 0) ? 0 : 2;
          else if (cyc == m_next) begin
            m_active--; m_next = cyc + STEP;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    chk("m_state",      64'(bus.state),      64'(m_state));
    chk("m_active_cnt", 64'(bus.active_cnt), 64'(m_active));
    chk("m_enable",     64'(bus.enable),     64'(thermo(m_active)));
    chk("m_ramp_done",  64'(bus.ramp_done),  64'(m_state == 2));
    chk("m_err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
    chk("m_err_count",  64'(bus.err_count),  64'(m_count));
    chk("m_err_clear",  64'(bus.err_clear),  64'(m_clear));
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (int'(bus.state) != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(bus.state), 64'(s));
  endtask

  task automatic pulse_sw_clear();
    bus.sw_clear = 1'b1;
    @(negedge clk);
    bus.sw_clear = 1'b0;
  endtask

  // Watchdog: a hung run still reports.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0; bus.stop = 0; bus.target = '0; bus.abort_on_err = 0;
    bus.sw_clear = 0; bus.error = '0;
    cycles(3);
    rst = 1'b0;
    chk("rst_state",  64'(bus.state), 0);
    chk("rst_enable", 64'(bus.enable), 0);
    chk("rst_count",  64'(bus.err_count), 0);

    // Ramp up to 3 heaters.
    bus.target = 6'd3; bus.start = 1'b1;
    cycles(1); bus.start = 1'b0;
    chk("up_state1", 64'(bus.state), 1);
    cycles(4); chk("up_act1", 64'(bus.active_cnt), 1);
    cycles(4); chk("up_act2", 64'(bus.active_cnt), 2);
    cycles(4); chk("up_act3", 64'(bus.active_cnt), 3);
    cycles(1);
    chk("up_hold", 64'(bus.state), 2);
    chk("up_done", 64'(bus.ramp_done), 1);
    chk("up_enable", 64'(bus.enable), 64'h7);

    // Two simultaneous errors on enabled heaters, then one on a disabled heater.
    bus.error = 32'h5;
    cycles(3);
    chk("err_sticky", 64'(bus.err_sticky), 64'h5);
    chk("err_count",  64'(bus.err_count), 2);
    chk("err_clear",  64'(bus.err_clear), 64'h5);
    cycles(1); chk("err_clear_off", 64'(bus.err_clear), 0);
    bus.error = 32'h405;
    cycles(5);
    chk("dis_sticky", 64'(bus.err_sticky), 64'h5);
    chk("dis_count",  64'(bus.err_count), 2);
    bus.error = '0;
    cycles(3);

    // Ramp down from 3 to 1.
    bus.target = 6'd1;
    cycles(1); chk("dn_state", 64'(bus.state), 3);
    cycles(4); chk("dn_act2", 64'(bus.active_cnt), 2);
    cycles(4); chk("dn_act1", 64'(bus.active_cnt), 1);
    cycles(1);
    chk("dn_hold", 64'(bus.state), 2);
    chk("dn_enable", 64'(bus.enable), 64'h1);

    // Stop to idle, then software clear.
    bus.stop = 1'b1; cycles(1); bus.stop = 1'b0;
    wait_state(0, 20, "stop_idle");
    pulse_sw_clear();
    chk("swc_count",  64'(bus.err_count), 0);
    chk("swc_sticky", 64'(bus.err_sticky), 0);
    chk("swc_clear",  64'(bus.err_clear), 64'hffff_ffff);
    cycles(1); chk("swc_clear_off", 64'(bus.err_clear), 0);

    // Abort on error mid ramp-up.
    bus.abort_on_err = 1'b1; bus.target = 6'd5; bus.start = 1'b1;
    cycles(1); bus.start = 1'b0;
    cycles(8); chk("ab_act2", 64'(bus.active_cnt), 2);
    bus.error = 32'h2;
    cycles(3);
    chk("ab_state", 64'(bus.state), 3);
    wait_state(0, 40, "ab_idle");
    chk("ab_active", 64'(bus.active_cnt), 0);
    chk("ab_count",  64'(bus.err_count), 1);
    bus.error = '0; bus.abort_on_err = 1'b0;
    cycles(3);

    // Counter saturation with CNT_W = 2.
    pulse_sw_clear();
    bus.target = 6'd4; bus.start = 1'b1;
    cycles(1); bus.start = 1'b0;
    wait_state(2, 60, "sat_hold");
    bus.error = 32'hf;
    cycles(3);
    chk("sat_count3", 64'(bus.err_count), 3);
    chk("sat_sticky", 64'(bus.err_sticky), 64'hf);
    bus.error = '0; cycles(3);
    bus.error = 32'h1; cycles(3);
    chk("sat_hold3", 64'(bus.err_count), 3);
    bus.error = '0;
    pulse_sw_clear();
    chk("sat_clr_count",  64'(bus.err_count), 0);
    chk("sat_clr_sticky", 64'(bus.err_sticky), 0);
    chk("sat_clr_pulse",  64'(bus.err_clear), 64'hffff_ffff);

    // Asynchronous reset mid ramp-up.
    bus.stop = 1'b1; cycles(1); bus.stop = 1'b0;
    wait_state(0, 60, "pre_rst_idle");
    bus.target = 6'd3; bus.start = 1'b1;
    cycles(1); bus.start = 1'b0;
    cycles(8); chk("rst_mid_act", 64'(bus.active_cnt), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_enable", 64'(bus.enable), 0);
    chk("arst_state",  64'(bus.state), 0);
    chk("arst_active", 64'(bus.active_cnt), 0);
    @(negedge clk); rst = 1'b0;

    // start and stop together in idle.
    bus.start = 1'b1; bus.stop = 1'b1;
    cycles(5);
    chk("ss_state",  64'(bus.state), 0);
    chk("ss_enable", 64'(bus.enable), 0);
    bus.start = 1'b0; bus.stop = 1'b0;

    // Randomized commands and errors.
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.stop     = ($urandom_range(0, 39) == 0);
      bus.sw_clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) bus.target = 6'($urandom_range(0, 40));
      if ($urandom_range(0, 99) == 0) bus.abort_on_err = ~bus.abort_on_err;
      if ($urandom_range(0, 3) == 0)  bus.error[$urandom_range(0, N-1)] ^= 1'b1;
    end

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
